// File: rtl/wb_regfile.sv
// Write-back stage: commits the bundle to R0-R3, the output port and the sticky halt flag.
// Read ports return the value being committed this cycle, so decode sees zero-latency results.
module wb_regfile #(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] SP_RESET = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        wb_ra,
  input  logic [1:0]        wb_rb,
  input  logic              wb_RW,
  input  logic [1:0]        wb_SP,
  input  logic              wb_SW1,
  input  logic              wb_SW2,
  input  logic              wb_out_ld,
  input  logic [DATA_W-1:0] wb_DataOut,
  input  logic              wb_Hlt,
  input  logic [1:0]        rd_addr_a,
  input  logic [1:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] sp_value,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
  output logic              halted
);

  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] regs_d [4];
  logic [DATA_W-1:0] out_port_q, out_port_d;
  logic              out_valid_q, out_valid_d;
  logic              halted_q, halted_d;
  logic              commit;
  logic [1:0]        dest;

  assign commit = ~halted_q;
  assign dest   = wb_SW1 ? wb_ra : wb_rb;

  always_comb begin
    regs_d      = regs_q;
    out_port_d  = out_port_q;
    out_valid_d = 1'b0;
    halted_d    = halted_q;
    if (commit) begin
      if (wb_SP == 2'b01) begin
        regs_d[3] = regs_q[3] + DATA_W'(1);
      end else if (wb_SP == 2'b10) begin
        regs_d[3] = regs_q[3] - DATA_W'(1);
      end
      // Applied after the SP op so a write to R3 overrides a concurrent inc/dec.
      if (wb_RW) begin
        regs_d[dest] = wb_SW2 ? regs_q[wb_ra] : wb_DataOut;
      end
      if (wb_out_ld) begin
        out_port_d  = wb_DataOut;
        out_valid_d = 1'b1;
      end
      if (wb_Hlt) begin
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q[0]   <= '0;
      regs_q[1]   <= '0;
      regs_q[2]   <= '0;
      regs_q[3]   <= SP_RESET;
      out_port_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      out_port_q  <= out_port_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
    end
  end

  // With commit low regs_d equals regs_q, so this also covers the non-bypassed case.
  assign rd_data_a = regs_d[rd_addr_a];
  assign rd_data_b = regs_d[rd_addr_b];
  assign sp_value  = regs_q[3];
  assign out_port  = out_port_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;

endmodule
